// File: rtl/char_buffer_pkg.sv
// rtl/char_buffer_pkg.sv - shared sizes, fill character and fill FSM encoding
package char_buffer_pkg;

  localparam int ADDR_WIDTH  = 11;
  localparam int DATA_WIDTH  = 8;
  localparam int COLS        = 80;
  localparam int ROWS        = 25;
  localparam int SCREEN_SIZE = COLS * ROWS;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/char_fill_seq.sv
// rtl/char_fill_seq.sv - block-fill sequencer: latches a range, clamps it to the screen, walks it
module char_fill_seq #(
  parameter int ADDR_WIDTH  = char_buffer_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH  = char_buffer_pkg::DATA_WIDTH,
  parameter int SCREEN_SIZE = char_buffer_pkg::SCREEN_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] from,
  input  logic [ADDR_WIDTH-1:0] to,
  input  logic [DATA_WIDTH-1:0] char_in,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);
  import char_buffer_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(SCREEN_SIZE - 1);

  fill_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [ADDR_WIDTH-1:0] clamped;
  logic [DATA_WIDTH-1:0] char_q, char_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    char_d  = char_q;
    done_d  = 1'b0;
    clamped = (to > LAST_CELL) ? LAST_CELL : to;
    case (state_q)
      IDLE: begin
        if (start) begin
          char_d = char_in;
          last_d = clamped;
          // An empty range still reports completion so the decoder can move on.
          if (from > clamped) begin
            done_d = 1'b1;
          end else begin
            ptr_d   = from;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (!stall) begin
          if (ptr_q == last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      char_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      char_q  <= char_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == FILL);
  assign req  = (state_q == FILL);
  assign done = done_q;
  assign addr = ptr_q;
  assign data = char_q;

endmodule

// File: rtl/char_buffer_arbiter.sv
// rtl/char_buffer_arbiter.sv - single-port char RAM arbiter: video reads over fill over host writes
module char_buffer_arbiter #(
  parameter int ADDR_WIDTH  = char_buffer_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH  = char_buffer_pkg::DATA_WIDTH,
  parameter int SCREEN_SIZE = char_buffer_pkg::SCREEN_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_valid,
  output logic [DATA_WIDTH-1:0] vid_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_from,
  input  logic [ADDR_WIDTH-1:0] fill_to,
  input  logic [DATA_WIDTH-1:0] fill_char,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout
);
  import char_buffer_pkg::*;

  logic                  seq_req;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic [DATA_WIDTH-1:0] seq_data;
  logic                  vid_valid_q, vid_valid_d;

  char_fill_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SCREEN_SIZE(SCREEN_SIZE)
  ) u_fill (
    .clk    (clk),
    .reset  (reset),
    .start  (fill_start),
    .from   (fill_from),
    .to     (fill_to),
    .char_in(fill_char),
    .stall  (vid_req),
    .busy   (fill_busy),
    .done   (fill_done),
    .req    (seq_req),
    .addr   (seq_addr),
    .data   (seq_data)
  );

  // Host writes wait for the whole fill so a later character cannot be erased by an earlier clear.
  always_comb begin
    mem_addr    = vid_addr;
    mem_din     = wr_data;
    mem_we      = 1'b0;
    wr_ack      = 1'b0;
    vid_valid_d = vid_req;
    if (!reset && !vid_req) begin
      if (seq_req) begin
        mem_addr = seq_addr;
        mem_din  = seq_data;
        mem_we   = 1'b1;
      end else if (wr_req && !fill_busy) begin
        mem_addr = wr_addr;
        mem_we   = 1'b1;
        wr_ack   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vid_valid_q <= 1'b0;
    end else begin
      vid_valid_q <= vid_valid_d;
    end
  end

  assign vid_valid = vid_valid_q;
  assign vid_data  = mem_dout;

endmodule

// File: tb/tb_char_buffer_arbiter.sv
// tb/tb_char_buffer_arbiter.sv - directed self-checking bench for char_buffer_arbiter
module tb_char_buffer_arbiter;

  logic        clk;
  logic        reset;
  logic        vid_req;
  logic [10:0] vid_addr;
  logic        vid_valid;
  logic [7:0]  vid_data;
  logic        wr_req;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        fill_start;
  logic [10:0] fill_from;
  logic [10:0] fill_to;
  logic [7:0]  fill_char;
  logic        fill_busy;
  logic        fill_done;
  logic [10:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;

  logic [7:0]  ram [2048];
  logic        pre_we;
  logic [10:0] pre_addr;
  logic [7:0]  pre_data;

  int total;
  int bad;

  char_buffer_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_valid (vid_valid),
    .vid_data  (vid_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .fill_start(fill_start),
    .fill_from (fill_from),
    .fill_to   (fill_to),
    .fill_char (fill_char),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick;
    pre_we = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; wr_req = 1'b1; wr_addr = 11'd3; wr_data = 8'hAA;
    fill_start = 1'b1; fill_from = 11'd0; fill_to = 11'd10; fill_char = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick; #2;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we cyc%0d got=%b want=0", i, mem_we); end
      total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL reset_wr_ack cyc%0d got=%b want=0", i, wr_ack); end
      total++; if (fill_busy !== 1'b0) begin bad++; $display("FAIL reset_fill_busy cyc%0d got=%b want=0", i, fill_busy); end
      total++; if (vid_valid !== 1'b0) begin bad++; $display("FAIL reset_vid_valid cyc%0d got=%b want=0", i, vid_valid); end
    end
    reset = 1'b0; wr_req = 1'b0; fill_start = 1'b0;
    tick; #2;
    total++; if (fill_busy !== 1'b0 || fill_done !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle got busy=%b done=%b we=%b want 0 0 0", fill_busy, fill_done, mem_we);
    end
  endtask

  task automatic test_video_read;
    preload(11'd5, 8'h41);
    vid_req = 1'b1; vid_addr = 11'd5; wr_req = 1'b1; wr_addr = 11'd7; wr_data = 8'h55;
    #2;
    total++; if (mem_addr !== 11'd5 || mem_we !== 1'b0) begin bad++; $display("FAIL vid_grant got addr=%0d we=%b want 5 0", mem_addr, mem_we); end
    total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL vid_blocks_ack got=%b want=0", wr_ack); end
    tick;
    vid_req = 1'b0;
    #2;
    total++; if (vid_valid !== 1'b1 || vid_data !== 8'h41) begin bad++; $display("FAIL vid_data got valid=%b data=%h want 1 41", vid_valid, vid_data); end
    total++; if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'd7) begin
      bad++; $display("FAIL ack_after_vid got ack=%b we=%b addr=%0d want 1 1 7", wr_ack, mem_we, mem_addr);
    end
    tick;
    wr_req = 1'b0;
    #2;
    total++; if (ram[7] !== 8'h55) begin bad++; $display("FAIL ram7 got=%h want=55", ram[7]); end
    total++; if (vid_valid !== 1'b0) begin bad++; $display("FAIL vid_valid_drop got=%b want=0", vid_valid); end
  endtask

  task automatic test_host_write;
    wr_req = 1'b1; wr_addr = 11'd10; wr_data = 8'h42;
    #2;
    total++; if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'd10 || mem_din !== 8'h42) begin
      bad++; $display("FAIL host_write got ack=%b we=%b addr=%0d din=%h want 1 1 10 42", wr_ack, mem_we, mem_addr, mem_din);
    end
    tick;
    wr_req = 1'b0; vid_req = 1'b1; vid_addr = 11'd10;
    tick;
    vid_req = 1'b0;
    #2;
    total++; if (vid_valid !== 1'b1 || vid_data !== 8'h42) begin bad++; $display("FAIL host_readback got valid=%b data=%h want 1 42", vid_valid, vid_data); end
  endtask

  task automatic test_screen_clear;
    int writes, bad_addr, acks, busy_low, early_done;
    writes = 0; bad_addr = 0; acks = 0; busy_low = 0; early_done = 0;
    fill_start = 1'b1; fill_from = 11'd0; fill_to = 11'd1999; fill_char = 8'h20;
    tick;
    fill_start = 1'b0; wr_req = 1'b1; wr_addr = 11'd2000; wr_data = 8'h99;
    for (int c = 1; c <= 2000; c++) begin
      #2;
      if (mem_we) begin
        writes++;
        if (mem_addr !== 11'(c - 1) || mem_din !== 8'h20) bad_addr++;
      end
      if (wr_ack) acks++;
      if (!fill_busy) busy_low++;
      if (fill_done) early_done++;
      tick;
    end
    #2;
    total++; if (writes !== 2000) begin bad++; $display("FAIL clear_writes got=%0d want=2000", writes); end
    total++; if (bad_addr !== 0) begin bad++; $display("FAIL clear_seq got=%0d bad cells want=0", bad_addr); end
    total++; if (acks !== 0) begin bad++; $display("FAIL clear_ack_during_fill got=%0d want=0", acks); end
    total++; if (busy_low !== 0 || early_done !== 0) begin bad++; $display("FAIL clear_busy got low=%0d early_done=%0d want 0 0", busy_low, early_done); end
    total++; if (fill_done !== 1'b1 || fill_busy !== 1'b0) begin bad++; $display("FAIL clear_done_2001 got done=%b busy=%b want 1 0", fill_done, fill_busy); end
    total++; if (wr_ack !== 1'b1 || mem_addr !== 11'd2000) begin bad++; $display("FAIL clear_ack_after got ack=%b addr=%0d want 1 2000", wr_ack, mem_addr); end
    tick;
    wr_req = 1'b0;
    #2;
    total++; if (fill_done !== 1'b0) begin bad++; $display("FAIL clear_done_pulse got=%b want=0", fill_done); end
    total++; if (ram[0] !== 8'h20 || ram[1999] !== 8'h20 || ram[2000] !== 8'h99) begin
      bad++; $display("FAIL clear_ram got %h %h %h want 20 20 99", ram[0], ram[1999], ram[2000]);
    end
  endtask

  task automatic test_clamp_and_empty;
    int writes, out_range, cyc;
    writes = 0; out_range = 0; cyc = 0;
    fill_start = 1'b1; fill_from = 11'd1990; fill_to = 11'd2047; fill_char = 8'h2A;
    tick;
    fill_start = 1'b0;
    #2;
    while (!fill_done && cyc < 50) begin
      if (mem_we) begin
        writes++;
        if (mem_addr < 11'd1990 || mem_addr > 11'd1999) out_range++;
      end
      cyc++;
      tick; #2;
    end
    total++; if (fill_done !== 1'b1) begin bad++; $display("FAIL clamp_timeout got done=%b want=1", fill_done); end
    total++; if (writes !== 10 || out_range !== 0) begin bad++; $display("FAIL clamp_writes got=%0d out=%0d want 10 0", writes, out_range); end
    total++; if (ram[1999] !== 8'h2A || ram[2000] !== 8'h99) begin bad++; $display("FAIL clamp_ram got %h %h want 2a 99", ram[1999], ram[2000]); end
    tick;
    fill_start = 1'b1; fill_from = 11'd50; fill_to = 11'd40; fill_char = 8'hEE;
    #2;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL empty_we0 got=%b want=0", mem_we); end
    tick;
    fill_start = 1'b0;
    #2;
    total++; if (fill_done !== 1'b1 || fill_busy !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL empty_done got done=%b busy=%b we=%b want 1 0 0", fill_done, fill_busy, mem_we);
    end
    tick; #2;
    total++; if (fill_done !== 1'b0 || ram[50] !== 8'h20 || ram[40] !== 8'h20) begin
      bad++; $display("FAIL empty_after got done=%b r50=%h r40=%h want 0 20 20", fill_done, ram[50], ram[40]);
    end
  endtask

  task automatic test_stalls;
    int expect_ptr, badw, cyc;
    logic [7:0] r;
    expect_ptr = 100; badw = 0; cyc = 0;
    fill_start = 1'b1; fill_from = 11'd100; fill_to = 11'd109; fill_char = 8'h77;
    tick;
    fill_start = 1'b0;
    cyc = 1;
    while (!fill_done && cyc < 40) begin
      vid_req = cyc[0]; vid_addr = 11'd0;
      #2;
      if (vid_req) begin
        if (mem_we !== 1'b0) badw++;
      end else begin
        if (mem_we !== 1'b1 || mem_addr !== 11'(expect_ptr)) badw++;
        expect_ptr++;
      end
      tick;
      cyc++;
      vid_req = 1'b0;
      #2;
    end
    total++; if (badw !== 0) begin bad++; $display("FAIL stall_pattern got=%0d bad cycles want=0", badw); end
    total++; if (expect_ptr !== 110) begin bad++; $display("FAIL stall_writes got=%0d want=10", expect_ptr - 100); end
    total++; if (cyc !== 21 || fill_done !== 1'b1) begin bad++; $display("FAIL stall_done_cycle got=%0d done=%b want 21 1", cyc, fill_done); end
    r = ram[109];
    total++; if (r !== 8'h77) begin bad++; $display("FAIL stall_ram109 got=%h want=77", r); end
    tick;
  endtask

  task automatic test_reset_mid_fill;
    int spurious, untouched;
    spurious = 0; untouched = 0;
    fill_start = 1'b1; fill_from = 11'd100; fill_to = 11'd109; fill_char = 8'h55;
    tick;
    fill_start = 1'b0;
    for (int c = 1; c <= 4; c++) tick;
    reset = 1'b1;
    #2;
    total++; if (mem_we !== 1'b0 || mem_addr === 11'd104 && mem_we === 1'b1) begin bad++; $display("FAIL midreset_we got=%b want=0", mem_we); end
    tick;
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      #2;
      if (fill_done || mem_we || fill_busy) spurious++;
      tick;
    end
    total++; if (spurious !== 0) begin bad++; $display("FAIL midreset_activity got=%0d want=0", spurious); end
    total++; if (ram[100] !== 8'h55 || ram[103] !== 8'h55) begin bad++; $display("FAIL midreset_written got %h %h want 55 55", ram[100], ram[103]); end
    for (int a = 104; a <= 109; a++) if (ram[a] !== 8'h77) untouched++;
    total++; if (untouched !== 0) begin bad++; $display("FAIL midreset_untouched got=%0d changed want=0", untouched); end
  endtask

  task automatic test_back_to_back;
    fill_start = 1'b1; fill_from = 11'd200; fill_to = 11'd201; fill_char = 8'h11;
    wr_req = 1'b1; wr_addr = 11'd300; wr_data = 8'h33;
    #2;
    total++; if (wr_ack !== 1'b1 || mem_addr !== 11'd300) begin bad++; $display("FAIL b2b_ack got ack=%b addr=%0d want 1 300", wr_ack, mem_addr); end
    tick;
    fill_start = 1'b0; wr_req = 1'b0;
    #2;
    total++; if (fill_busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'd200 || mem_din !== 8'h11) begin
      bad++; $display("FAIL b2b_fill got busy=%b we=%b addr=%0d din=%h want 1 1 200 11", fill_busy, mem_we, mem_addr, mem_din);
    end
    tick; tick; #2;
    total++; if (fill_done !== 1'b1 || ram[300] !== 8'h33 || ram[201] !== 8'h11) begin
      bad++; $display("FAIL b2b_result got done=%b r300=%h r201=%h want 1 33 11", fill_done, ram[300], ram[201]);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; vid_req = 1'b0; vid_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    fill_start = 1'b0; fill_from = '0; fill_to = '0; fill_char = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset;
    test_video_read;
    test_host_write;
    test_screen_clear;
    test_clamp_and_empty;
    test_stalls;
    test_reset_mid_fill;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
